// File: rtl/flag_unit.sv
// Condition-flag producer: computes {V,N,Z} in EX, stages them FLAG_LAT-1 cycles,
// commits them to the flag register and stalls conditional branches on pending writes.
module flag_unit #(
    parameter int unsigned FLAG_LAT = 1  // legal range 1..3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic        id_branch,
    input  logic [2:0]  id_cond,
    output logic [2:0]  flags,
    output logic        stall_id,
    output logic [15:0] stall_cnt
);

    localparam int unsigned NSLOT   = FLAG_LAT - 1;
    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic              valid;
        logic [FLAG_W-1:0] mask;
        logic [FLAG_W-1:0] val;
    } flag_ent_t;

    logic [FLAG_W-1:0] ex_mask;
    logic              ex_wr;
    flag_ent_t         ex_ent;
    flag_ent_t         commit_ent;
    logic              any_pend;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Opcode -> which flag bits this instruction writes; unknown opcodes write nothing.
    always_comb begin
        ex_mask = 3'b000;
        case (ex_opcode)
            4'b0000, 4'b0001:          ex_mask = 3'b111;
            4'b0010, 4'b0100,
            4'b0101, 4'b0110:          ex_mask = 3'b001;
            default:                   ex_mask = 3'b000;
        endcase
    end

    always_comb begin
        ex_wr        = ex_valid & ~ex_flush & (ex_mask != 3'b000);
        ex_ent.valid = ex_wr;
        ex_ent.mask  = ex_mask;
        ex_ent.val   = {ex_ovfl, ex_result[15], (ex_result == 16'h0000)};
    end

    generate
        if (NSLOT == 0) begin : g_direct
            assign commit_ent = ex_ent;
            assign any_pend   = 1'b0;
        end else begin : g_pipe
            flag_ent_t slot_q [NSLOT];
            flag_ent_t slot_d [NSLOT];
            logic      pend;

            // Slot 0 takes the EX entry; the last slot feeds the commit.
            always_comb begin
                slot_d[0] = ex_ent;
                for (int i = 1; i < int'(NSLOT); i++) begin
                    slot_d[i] = slot_q[i-1];
                end
                pend = 1'b0;
                for (int i = 0; i < int'(NSLOT); i++) begin
                    pend = pend | slot_q[i].valid;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(NSLOT); i++) begin
                        slot_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < int'(NSLOT); i++) begin
                        slot_q[i] <= slot_d[i];
                    end
                end
            end

            assign commit_ent = slot_q[NSLOT-1];
            assign any_pend   = pend;
        end
    endgenerate

    // Masked merge keeps bits the committing instruction does not own.
    always_comb begin
        flags_d = flags_q;
        if (commit_ent.valid) begin
            flags_d = (flags_q & ~commit_ent.mask) | (commit_ent.val & commit_ent.mask);
        end
    end

    always_comb begin
        stall_id = id_branch & (id_cond != 3'b111) & (ex_wr | any_pend);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flags     = flags_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: three instances (FLAG_LAT=1,2,3) share one stimulus stream.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_flush, ex_ovfl, id_branch;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic [2:0]  id_cond;

    logic [2:0]  flags1, flags2, flags3;
    logic        stall1, stall2, stall3;
    logic [15:0] cnt1, cnt2, cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flag_unit #(.FLAG_LAT(1)) u1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
        .id_branch(id_branch), .id_cond(id_cond),
        .flags(flags1), .stall_id(stall1), .stall_cnt(cnt1));

    flag_unit #(.FLAG_LAT(2)) u2 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
        .id_branch(id_branch), .id_cond(id_cond),
        .flags(flags2), .stall_id(stall2), .stall_cnt(cnt2));

    flag_unit #(.FLAG_LAT(3)) u3 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
        .id_branch(id_branch), .id_cond(id_cond),
        .flags(flags3), .stall_id(stall3), .stall_cnt(cnt3));

    typedef struct {
        logic        valid;
        logic        flush;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic        br;
        logic [2:0]  cond;
        logic [2:0]  exp_flags;
        logic        exp_stall;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    logic [2:0] exp_q [$];

    function automatic vec_t mk(logic v, logic f, logic [3:0] op, logic [15:0] res,
                                logic ov, logic br, logic [2:0] cond,
                                logic [2:0] ef, logic es);
        vec_t t;
        t.valid = v; t.flush = f; t.op = op; t.res = res; t.ovfl = ov;
        t.br = br; t.cond = cond; t.exp_flags = ef; t.exp_stall = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] op,
                         input logic [15:0] res, input logic ov,
                         input logic br, input logic [2:0] cond);
        ex_valid = v; ex_flush = f; ex_opcode = op; ex_result = res;
        ex_ovfl = ov; id_branch = br; id_cond = cond;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int s1, s2, s3;
        logic [2:0] expf;

        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 3'b000);
        // Flag sequence for FLAG_LAT=1, each row starting from the previous row's flags.
        vecs[0]  = mk(1, 0, 4'b0000, 16'h0000, 0, 0, 3'b000, 3'b001, 0); // ADD zero
        vecs[1]  = mk(1, 0, 4'b0001, 16'h8000, 1, 0, 3'b000, 3'b110, 0); // SUB neg ovfl
        vecs[2]  = mk(1, 0, 4'b0010, 16'h0005, 0, 0, 3'b000, 3'b110, 0); // XOR keeps V,N
        vecs[3]  = mk(1, 0, 4'b0100, 16'h0000, 0, 0, 3'b000, 3'b111, 0); // SLL sets Z
        vecs[4]  = mk(1, 0, 4'b0011, 16'h0000, 1, 0, 3'b000, 3'b111, 0); // no-flag opcode
        vecs[5]  = mk(1, 0, 4'b0000, 16'h0001, 0, 0, 3'b000, 3'b000, 0); // ADD clears all
        vecs[6]  = mk(1, 0, 4'b0110, 16'h0000, 0, 0, 3'b000, 3'b001, 0); // ROR zero
        vecs[7]  = mk(1, 0, 4'b0101, 16'h8000, 1, 0, 3'b000, 3'b000, 0); // SRA: Z only
        vecs[8]  = mk(1, 1, 4'b0000, 16'h0000, 0, 1, 3'b000, 3'b000, 0); // flushed ADD
        vecs[9]  = mk(0, 0, 4'b0000, 16'h0000, 0, 1, 3'b000, 3'b000, 0); // bubble
        vecs[10] = mk(1, 0, 4'b0000, 16'hFFFF, 1, 1, 3'b001, 3'b110, 1); // cond branch stalls
        vecs[11] = mk(1, 0, 4'b0000, 16'h0000, 0, 1, 3'b111, 3'b001, 0); // uncond never stalls
        vecs[12] = mk(1, 0, 4'b1111, 16'h0000, 0, 1, 3'b010, 3'b001, 0); // undefined opcode

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_flags1", 32'(flags1), 32'h0);
        chk("reset_flags3", 32'(flags3), 32'h0);
        chk("reset_stall1", 32'(stall1), 32'h0);
        chk("reset_cnt2",   32'(cnt2),   32'h0);

        // Table vectors, scoreboarded against the FLAG_LAT=1 instance.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].flush, vecs[i].op, vecs[i].res,
                  vecs[i].ovfl, vecs[i].br, vecs[i].cond);
            exp_q.push_back(vecs[i].exp_flags);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall1), 32'(vecs[i].exp_stall));
            tick();
            expf = exp_q.pop_front();
            chk($sformatf("vec%0d_flags", i), 32'(flags1), 32'(expf));
        end
        chk("table_cnt1", 32'(cnt1), 32'h1);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        // FLAG_LAT=2: one ADD ahead of a conditional branch.
        do_reset();
        drive(1, 0, 4'b0000, 16'h0000, 0, 1, 3'b001);
        #1 chk("l2_stall_c0", 32'(stall2), 32'h1);
        tick();
        @(negedge clk);
        ex_valid = 1'b0;
        #1 chk("l2_stall_c1", 32'(stall2), 32'h1);
        chk("l2_flags_c1", 32'(flags2), 32'h0);
        tick();
        chk("l2_stall_c2", 32'(stall2), 32'h0);
        chk("l2_flags_c2", 32'(flags2), 32'h1);
        chk("l2_cnt", 32'(cnt2), 32'h2);

        // Same shape with an unconditional branch, then with a non-branch in ID.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            s2 = 0;
            drive(1, 0, 4'b0000, 16'h0000, 0, (k == 0), (k == 0) ? 3'b111 : 3'b001);
            for (int c = 0; c < 4; c++) begin
                #1 if (stall2) s2++;
                tick();
                @(negedge clk);
                ex_valid = 1'b0;
            end
            chk($sformatf("nostall%0d_cycles", k), 32'(s2), 32'h0);
            chk($sformatf("nostall%0d_cnt", k), 32'(cnt2), 32'h0);
        end

        // Stall length vs latency, bounded window.
        do_reset();
        s1 = 0; s2 = 0; s3 = 0;
        drive(1, 0, 4'b0001, 16'h1234, 0, 1, 3'b100);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (stall1) s1++;
            if (stall2) s2++;
            if (stall3) s3++;
            tick();
            @(negedge clk);
            ex_valid = 1'b0;
        end
        chk("len_lat1", 32'(s1), 32'h1);
        chk("len_lat2", 32'(s2), 32'h2);
        chk("len_lat3", 32'(s3), 32'h3);
        chk("len_cnt3", 32'(cnt3), 32'h3);

        // Back-to-back writers commit in order through the deepest pipe; later flush is ignored for older.
        do_reset();
        drive(1, 0, 4'b0000, 16'hFFFF, 1, 0, 3'b000);
        tick();
        @(negedge clk);
        drive(1, 0, 4'b0010, 16'h0000, 0, 0, 3'b000);
        tick();
        @(negedge clk);
        drive(1, 1, 4'b0000, 16'h0001, 0, 0, 3'b000);
        tick();
        chk("order_add", 32'(flags3), 32'h6);
        @(negedge clk);
        ex_valid = 1'b0;
        tick();
        chk("order_xor", 32'(flags3), 32'h7);
        tick();
        chk("order_flushed", 32'(flags3), 32'h7);

        // Async reset with two entries pending and a branch stalled.
        do_reset();
        drive(1, 0, 4'b0000, 16'h0000, 0, 1, 3'b001);
        tick();
        @(negedge clk);
        drive(1, 0, 4'b0001, 16'h8000, 1, 1, 3'b001);
        tick();
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("rst_pre_stall3", 32'(stall3), 32'h1);
        chk("rst_pre_cnt3",   32'(cnt3),   32'h2);
        chk("rst_pre_flags2", 32'(flags2), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_flags3", 32'(flags3), 32'h0);
        chk("rst_stall3", 32'(stall3), 32'h0);
        chk("rst_cnt3",   32'(cnt3),   32'h0);
        chk("rst_flags2", 32'(flags2), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        id_branch = 1'b0;
        tick();
        chk("rst_after_flags3", 32'(flags3), 32'h0);

        // Saturation: continuous stall for more than 2^16 cycles.
        do_reset();
        drive(1, 0, 4'b0000, 16'h0000, 0, 1, 3'b001);
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt1", 32'(cnt1), 32'hFFFF);
        chk("sat_cnt3", 32'(cnt3), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(cnt1), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
